// File: rtl/instr_encoder_loader_if.sv
// Request stream and imem write port shared between a program source and the encoder/loader.
// The loader connects through the slave modport.
interface instr_encoder_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [12:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes abstract RV64 instruction requests into 32-bit words and writes them
// sequentially into instruction memory during a load session.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W:0]        instr_count,
    output logic                   misalign_err
);
    localparam logic [ADDR_W:0]   DepthC = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BaseC  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_t;

    state_t          state;
    logic            accept;
    logic [ADDR_W:0] count_inc;
    logic [31:0]     enc;

    assign bus.in_ready = (state == StLoad) && (instr_count < DepthC);
    assign accept       = bus.in_valid && bus.in_ready;
    assign count_inc    = instr_count + (ADDR_W + 1)'(1);

    always_comb begin
        enc = '0;
        case (bus.in_op)
            3'd0: enc = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, 7'b0110011};
            3'd1: enc = {7'b0100000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, 7'b0110011};
            3'd2: enc = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b111, bus.in_rd, 7'b0110011};
            3'd3: enc = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b110, bus.in_rd, 7'b0110011};
            3'd4: enc = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b0010011};
            3'd5: enc = {bus.in_imm[11:0], bus.in_rs1, 3'b011, bus.in_rd, 7'b0000011};
            3'd6: enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b011,
                         bus.in_imm[4:0], 7'b0100011};
            // imm[0] is not representable and is dropped.
            3'd7: enc = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                         bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
            default: enc = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= StIdle;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            instr_count    <= '0;
            misalign_err   <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            done        <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state        <= StLoad;
                        busy         <= 1'b1;
                        instr_count  <= '0;
                        misalign_err <= 1'b0;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= BaseC + instr_count[ADDR_W-1:0];
                        bus.imem_wdata <= enc;
                        instr_count    <= count_inc;
                        if (bus.in_op == 3'd7 && bus.in_imm[0]) begin
                            misalign_err <= 1'b1;
                        end
                        if (bus.in_last || count_inc == DepthC) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench: a default-size loader and a DEPTH=4/BASE_ADDR=254 loader side by side.
module tb_instr_encoder_loader;
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic valid0 = 1'b0, valid1 = 1'b0;
    logic [2:0]  op = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [12:0] imm = '0;
    logic        last = 1'b0;

    logic busy0, done0, mis0, busy1, done1, mis1;
    logic [8:0] cnt0_dut, cnt1_dut;

    exp_t q0[$];
    exp_t q1[$];
    int cnt0 = 0, cnt1 = 0;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    instr_encoder_loader_if #(.ADDR_W(8)) bus0 ();
    instr_encoder_loader_if #(.ADDR_W(8)) bus1 ();

    assign bus0.in_valid = valid0;
    assign bus0.in_op = op;
    assign bus0.in_rd = rd;
    assign bus0.in_rs1 = rs1;
    assign bus0.in_rs2 = rs2;
    assign bus0.in_imm = imm;
    assign bus0.in_last = last;
    assign bus1.in_valid = valid1;
    assign bus1.in_op = op;
    assign bus1.in_rd = rd;
    assign bus1.in_rs1 = rs1;
    assign bus1.in_rs2 = rs2;
    assign bus1.in_imm = imm;
    assign bus1.in_last = last;

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0),
        .busy(busy0), .done(done0), .instr_count(cnt0_dut), .misalign_err(mis0)
    );

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(254)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1),
        .busy(busy1), .done(done1), .instr_count(cnt1_dut), .misalign_err(mis1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_model(input logic [2:0] o, input logic [4:0] d,
                                              input logic [4:0] s1, input logic [4:0] s2,
                                              input logic [12:0] im);
        int unsigned w, i;
        int unsigned opc [8] = '{'h33, 'h33, 'h33, 'h33, 'h13, 'h03, 'h23, 'h63};
        int unsigned f3  [8] = '{0, 0, 7, 6, 0, 3, 3, 0};
        i = 32'(im);
        w = opc[o] | (f3[o] << 12) | (32'(s1) << 15);
        if (o <= 3'd3) w = w | (32'(d) << 7) | (32'(s2) << 20);
        if (o == 3'd1) w = w | (32'h20 << 25);
        if (o == 3'd4 || o == 3'd5) w = w | (32'(d) << 7) | ((i & 'hfff) << 20);
        if (o == 3'd6) w = w | (32'(s2) << 20) | ((i & 'h1f) << 7) | (((i >> 5) & 'h7f) << 25);
        if (o == 3'd7) begin
            w = w | (32'(s2) << 20) | (((i >> 12) & 1) << 31) | (((i >> 5) & 'h3f) << 25)
                  | (((i >> 1) & 'hf) << 8) | (((i >> 11) & 1) << 7);
        end
        return w;
    endfunction

    always @(negedge clk) begin : mon0
        exp_t e;
        if (bus0.imem_we) begin
            if (q0.size() == 0) check_eq("d0_unexpected_we", 64'(q0.size()), 64'd1);
            else begin
                e = q0.pop_front();
                check_eq("d0_addr", 64'(bus0.imem_addr), 64'(e.addr));
                check_eq("d0_wdata", 64'(bus0.imem_wdata), 64'(e.data));
                check_eq("d0_done", 64'(done0), 64'(e.done));
            end
        end else if (done0) check_eq("d0_done_without_we", 64'(bus0.imem_we), 64'd1);
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (bus1.imem_we) begin
            if (q1.size() == 0) check_eq("d1_unexpected_we", 64'(q1.size()), 64'd1);
            else begin
                e = q1.pop_front();
                check_eq("d1_addr", 64'(bus1.imem_addr), 64'(e.addr));
                check_eq("d1_wdata", 64'(bus1.imem_wdata), 64'(e.data));
                check_eq("d1_done", 64'(done1), 64'(e.done));
            end
        end else if (done1) check_eq("d1_done_without_we", 64'(bus1.imem_we), 64'd1);
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input bit sel, input logic [2:0] o, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im,
                        input bit lst, input logic [31:0] exp_word);
        int waitc = 0;
        logic rdy;
        exp_t e;
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; last = lst;
        if (sel) valid1 = 1'b1; else valid0 = 1'b1;
        @(negedge clk);
        rdy = sel ? bus1.in_ready : bus0.in_ready;
        while (!rdy && waitc < 50) begin
            @(negedge clk);
            rdy = sel ? bus1.in_ready : bus0.in_ready;
            waitc++;
        end
        if (!rdy) check_eq("ready_timeout", 64'(rdy), 64'd1);
        else begin
            e.data = exp_word;
            if (sel) begin
                e.addr = 8'(254 + cnt1);
                cnt1++;
                e.done = lst || cnt1 == 4;
                q1.push_back(e);
            end else begin
                e.addr = 8'(cnt0);
                cnt0++;
                e.done = lst || cnt0 == 256;
                q0.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        last = 1'b0;
    endtask

    task automatic start_session(input bit sel);
        if (sel) begin start1 = 1'b1; cnt1 = 0; end
        else begin start0 = 1'b1; cnt0 = 0; end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] ro;
        logic [4:0] r1, r2, r3;
        logic [12:0] ri;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 64'(bus0.in_ready), 64'd0);
        check_eq("rst_we", 64'(bus0.imem_we), 64'd0);
        check_eq("rst_busy", 64'(busy0), 64'd0);
        check_eq("rst_done", 64'(done0), 64'd0);
        check_eq("rst_count", 64'(cnt0_dut), 64'd0);
        check_eq("rst_mis", 64'(mis0), 64'd0);
        rst_n = 1'b1;
        idle(1);

        // R-type pair
        start_session(0);
        check_eq("t1_busy", 64'(busy0), 64'd1);
        send(0, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 32'h002081B3);
        send(0, 3'd1, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h402081B3);
        check_eq("t1_ready_in_done", 64'(bus0.in_ready), 64'd0);
        idle(2);
        check_eq("t1_count", 64'(cnt0_dut), 64'd2);
        check_eq("t1_busy_idle", 64'(busy0), 64'd0);

        // I/S types
        start_session(0);
        send(0, 3'd4, 5'd5, 5'd0, 5'd0, 13'd10, 1'b0, 32'h00A00293);
        send(0, 3'd5, 5'd6, 5'd2, 5'd0, 13'd8, 1'b0, 32'h00813303);
        send(0, 3'd6, 5'd0, 5'd2, 5'd6, 13'd16, 1'b1, 32'h00613823);
        idle(2);
        check_eq("t2_count", 64'(cnt0_dut), 64'd3);

        // BEQ and misalignment
        start_session(0);
        send(0, 3'd7, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b0, 32'hFE208CE3);
        check_eq("t3_mis_aligned", 64'(mis0), 64'd0);
        send(0, 3'd7, 5'd0, 5'd1, 5'd2, 13'h0005, 1'b1, 32'h00208263);
        check_eq("t3_mis_set", 64'(mis0), 64'd1);
        idle(4);
        check_eq("t3_mis_sticky", 64'(mis0), 64'd1);
        start_session(0);
        check_eq("t3_mis_cleared", 64'(mis0), 64'd0);

        // Gaps, randomised requests, start pulsed mid-load
        for (int i = 0; i < 8; i++) begin
            idle(int'($urandom_range(0, 2)));
            if (i == 4) begin
                start0 = 1'b1;
                idle(1);
                start0 = 1'b0;
                check_eq("t5_busy_after_start", 64'(busy0), 64'd1);
                check_eq("t5_count_kept", 64'(cnt0_dut), 64'(cnt0));
            end
            ro = 3'($urandom);
            r1 = 5'($urandom);
            r2 = 5'($urandom);
            r3 = 5'($urandom);
            ri = 13'($urandom) & 13'h1FFE;
            send(0, ro, r1, r2, r3, ri, i == 7, enc_model(ro, r1, r2, r3, ri));
        end
        idle(2);
        check_eq("t5_count", 64'(cnt0_dut), 64'd8);

        // Depth limit with address wrap
        start_session(1);
        for (int i = 0; i < 4; i++) begin
            send(1, 3'd2, 5'(i + 1), 5'd4, 5'd9, 13'd0, 1'b0, enc_model(3'd2, 5'(i + 1), 5'd4, 5'd9, 13'd0));
        end
        check_eq("t4_ready_after_4", 64'(bus1.in_ready), 64'd0);
        valid1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t4_ready_held_low", 64'(bus1.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        check_eq("t4_count", 64'(cnt1_dut), 64'd4);
        check_eq("t4_busy", 64'(busy1), 64'd0);

        // Reset right after an accept
        start_session(0);
        send(0, 3'd3, 5'd7, 5'd8, 5'd9, 13'd0, 1'b0, enc_model(3'd3, 5'd7, 5'd8, 5'd9, 13'd0));
        rst_n = 1'b0;
        idle(1);
        check_eq("t6_we", 64'(bus0.imem_we), 64'd0);
        check_eq("t6_busy", 64'(busy0), 64'd0);
        check_eq("t6_count", 64'(cnt0_dut), 64'd0);
        check_eq("t6_ready", 64'(bus0.in_ready), 64'd0);
        check_eq("t6_addr", 64'(bus0.imem_addr), 64'd0);
        check_eq("t6_wdata", 64'(bus0.imem_wdata), 64'd0);
        rst_n = 1'b1;
        idle(4);
        check_eq("t6_stay_idle", 64'(busy0), 64'd0);

        check_eq("sb0_empty", 64'(q0.size()), 64'd0);
        check_eq("sb1_empty", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
